// File: rtl/ones_pkg.sv
// Shared constants, output-buffer state encoding and the saturating adder
// used by the ones-count window accumulator.
package ones_pkg;

   localparam int unsigned CNT_W     = 2;
   localparam int unsigned MAX_SUM_W = 16;
   localparam int unsigned SUM_EXT_W = MAX_SUM_W + 1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_e;

   typedef struct packed {
      logic                 sat;
      logic [MAX_SUM_W-1:0] sum;
   } sat_sum_t;

   // a + b clipped at max_v; sat flags that clipping happened
   function automatic sat_sum_t sat_add(input logic [MAX_SUM_W-1:0] a,
                                        input logic [CNT_W-1:0]     b,
                                        input logic [MAX_SUM_W-1:0] max_v);
      logic [SUM_EXT_W-1:0] s;
      sat_sum_t             r;
      s = SUM_EXT_W'(a) + SUM_EXT_W'(b);
      if (s > SUM_EXT_W'(max_v)) begin
         r.sat = 1'b1;
         r.sum = max_v;
      end else begin
         r.sat = 1'b0;
         r.sum = s[MAX_SUM_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/ones_window_acc_if.sv
// Sample-in / window-result-out handshake bundle for ones_window_acc.
interface ones_window_acc_if
   import ones_pkg::*;
#(
   parameter int unsigned SUM_W = 8
);

   logic             in_valid;
   logic [CNT_W-1:0] in_count;
   logic             in_ready;
   logic             out_valid;
   logic [SUM_W-1:0] out_sum;
   logic             out_sat;
   logic             out_ready;

   modport master (
      output in_valid, in_count, out_ready,
      input  in_ready, out_valid, out_sum, out_sat
   );

   modport slave (
      input  in_valid, in_count, out_ready,
      output in_ready, out_valid, out_sum, out_sat
   );

endinterface

// File: rtl/ones_out_slice.sv
// One-entry result register with an EMPTY/FULL handshake FSM; holds the
// last completed window until the consumer takes it.
module ones_out_slice
   import ones_pkg::*;
#(
   parameter int unsigned SUM_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [SUM_W-1:0] load_sum,
   input  logic             load_sat,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [SUM_W-1:0] out_sum,
   output logic             out_sat
);

   out_state_e       state_q, state_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic             sat_q, sat_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         sum_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         sat_q   <= sat_d;
      end
   end

   // load is only raised while FULL when out_ready frees the slot the same cycle
   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      sat_d   = sat_q;
      case (state_q)
         EMPTY: begin
            if (load) begin
               state_d = FULL;
               sum_d   = load_sum;
               sat_d   = load_sat;
            end
         end
         FULL: begin
            if (out_ready) begin
               if (load) begin
                  sum_d = load_sum;
                  sat_d = load_sat;
               end else begin
                  state_d = EMPTY;
               end
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   assign out_valid = (state_q == FULL);
   assign out_sum   = sum_q;
   assign out_sat   = sat_q;

endmodule

// File: rtl/ones_window_acc.sv
// Sums WIN_LEN accepted ones-count samples with saturation and hands each
// completed window to a one-entry output buffer.
module ones_window_acc
   import ones_pkg::*;
#(
   parameter int unsigned WIN_LEN = 16,
   parameter int unsigned SUM_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   ones_window_acc_if.slave  bus
);

   localparam int unsigned          CNT_BITS = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam logic [CNT_BITS-1:0]  LAST_CNT = CNT_BITS'(WIN_LEN - 1);
   localparam logic [MAX_SUM_W-1:0] SUM_MAX  = MAX_SUM_W'((32'd1 << SUM_W) - 32'd1);

   logic [SUM_W-1:0]    acc_q, acc_d;
   logic                sat_q, sat_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;

   logic                out_valid;
   logic [SUM_W-1:0]    out_sum;
   logic                out_sat;

   logic                last_c;
   logic                in_ready_c;
   logic                accept_c;
   logic                close_c;
   sat_sum_t            add_c;
   logic [SUM_W-1:0]    win_sum_c;
   logic                win_sat_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         sat_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         sat_q <= sat_d;
         cnt_q <= cnt_d;
      end
   end

   // Only a window-closing sample can stall, and only while the buffer is blocked
   always_comb begin
      acc_d      = acc_q;
      sat_d      = sat_q;
      cnt_d      = cnt_q;
      last_c     = (cnt_q == LAST_CNT);
      in_ready_c = !(last_c && out_valid && !bus.out_ready);
      accept_c   = bus.in_valid && in_ready_c && !clear;
      close_c    = accept_c && last_c;
      add_c      = sat_add(MAX_SUM_W'(acc_q), bus.in_count, SUM_MAX);
      win_sum_c  = SUM_W'(add_c.sum);
      win_sat_c  = sat_q | add_c.sat;
      if (clear || close_c) begin
         acc_d = '0;
         sat_d = 1'b0;
         cnt_d = '0;
      end else if (accept_c) begin
         acc_d = win_sum_c;
         sat_d = win_sat_c;
         cnt_d = cnt_q + CNT_BITS'(1);
      end
   end

   ones_out_slice #(
      .SUM_W (SUM_W)
   ) u_out_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (close_c),
      .load_sum  (win_sum_c),
      .load_sat  (win_sat_c),
      .out_ready (bus.out_ready),
      .out_valid (out_valid),
      .out_sum   (out_sum),
      .out_sat   (out_sat)
   );

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid;
   assign bus.out_sum   = out_sum;
   assign bus.out_sat   = out_sat;

endmodule

// File: tb/tb_ones_window_acc.sv
// Bench for ones_window_acc: two instances (SUM_W=4 and SUM_W=3, WIN_LEN=4)
// share one stimulus stream and are checked against a behavioural scoreboard.
module tb_ones_window_acc;
   import ones_pkg::*;

   localparam int WIN = 4;

   typedef struct packed {
      logic [3:0] s4;
      logic       sat4;
      logic [2:0] s3;
      logic       sat3;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic       in_valid = 1'b0;
   logic [1:0] in_count = 2'd0;
   logic       out_ready = 1'b0;

   int   n_vec = 0;
   int   n_err = 0;
   int   n_acc = 0;

   exp_t exp_q[$];
   int   m_cnt = 0;
   int   m_acc4 = 0;
   int   m_acc3 = 0;
   bit   m_sat4 = 1'b0;
   bit   m_sat3 = 1'b0;
   bit   m_full = 1'b0;

   always #5 clk = ~clk;

   ones_window_acc_if #(.SUM_W(4)) bus4 ();
   ones_window_acc_if #(.SUM_W(3)) bus3 ();

   assign bus4.in_valid  = in_valid;
   assign bus4.in_count  = in_count;
   assign bus4.out_ready = out_ready;
   assign bus3.in_valid  = in_valid;
   assign bus3.in_count  = in_count;
   assign bus3.out_ready = out_ready;

   ones_window_acc #(.WIN_LEN(4), .SUM_W(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .bus   (bus4.slave)
   );

   ones_window_acc #(.WIN_LEN(4), .SUM_W(3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .bus   (bus3.slave)
   );

   // Mid-cycle monitor: check against the model, then advance it over the next edge
   always @(negedge clk) begin
      bit   exp_ready;
      bit   take;
      bit   close;
      int   s4;
      int   s3;
      exp_t e;
      if (!rst_n) begin
         m_cnt = 0; m_acc4 = 0; m_acc3 = 0; m_sat4 = 0; m_sat3 = 0; m_full = 0;
         exp_q.delete();
         n_vec++;
         if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_hold t=%0t got valid=%b ready=%b want valid=0 ready=1",
                     $time, bus4.out_valid, bus4.in_ready);
         end
      end else begin
         exp_ready = !(m_cnt == WIN - 1 && m_full && !out_ready);
         take      = m_full && out_ready;
         n_vec++;
         if (bus4.in_ready !== exp_ready || bus3.in_ready !== exp_ready) begin
            n_err++;
            $display("FAIL in_ready t=%0t got %b/%b want %b", $time,
                     bus4.in_ready, bus3.in_ready, exp_ready);
         end
         n_vec++;
         if (bus4.out_valid !== m_full || bus3.out_valid !== m_full) begin
            n_err++;
            $display("FAIL out_valid t=%0t got %b/%b want %b", $time,
                     bus4.out_valid, bus3.out_valid, m_full);
         end
         if (take) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL sb_empty t=%0t got result with no expected window", $time);
            end else begin
               e = exp_q.pop_front();
               if (bus4.out_sum !== e.s4 || bus4.out_sat !== e.sat4) begin
                  n_err++;
                  $display("FAIL sum4 t=%0t got %0d/%b want %0d/%b", $time,
                           bus4.out_sum, bus4.out_sat, e.s4, e.sat4);
               end
               n_vec++;
               if (bus3.out_sum !== e.s3 || bus3.out_sat !== e.sat3) begin
                  n_err++;
                  $display("FAIL sum3 t=%0t got %0d/%b want %0d/%b", $time,
                           bus3.out_sum, bus3.out_sat, e.s3, e.sat3);
               end
            end
         end
         close = 1'b0;
         if (clear) begin
            m_cnt = 0; m_acc4 = 0; m_acc3 = 0; m_sat4 = 0; m_sat3 = 0;
         end else if (in_valid && exp_ready) begin
            n_acc++;
            s4 = m_acc4 + int'(in_count);
            s3 = m_acc3 + int'(in_count);
            if (s4 > 15) begin s4 = 15; m_sat4 = 1'b1; end
            if (s3 > 7)  begin s3 = 7;  m_sat3 = 1'b1; end
            if (m_cnt == WIN - 1) begin
               e.s4 = 4'(s4); e.sat4 = m_sat4; e.s3 = 3'(s3); e.sat3 = m_sat3;
               exp_q.push_back(e);
               close = 1'b1;
               m_cnt = 0; m_acc4 = 0; m_acc3 = 0; m_sat4 = 0; m_sat3 = 0;
            end else begin
               m_cnt++;
               m_acc4 = s4;
               m_acc3 = s3;
            end
         end
         if (close)     m_full = 1'b1;
         else if (take) m_full = 1'b0;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid  = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b1;
      repeat (n) cyc();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      n_vec++;
      if (bus4.out_valid !== 1'b0 || bus4.out_sum !== 4'd0 || bus4.out_sat !== 1'b0 ||
          bus4.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_state got v=%b s=%0d sat=%b rdy=%b want 0/0/0/1",
                  bus4.out_valid, bus4.out_sum, bus4.out_sat, bus4.in_ready);
      end
      cyc(); cyc();
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_basic();
      logic [1:0] vals [4];
      vals = '{2'd1, 2'd2, 2'd3, 2'd0};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_count = vals[i];
         cyc();
      end
      in_valid = 1'b0;
      n_vec++;
      if (bus4.out_valid !== 1'b1 || bus4.out_sum !== 4'd6 || bus4.out_sat !== 1'b0) begin
         n_err++;
         $display("FAIL basic_sum got v=%b s=%0d sat=%b want 1/6/0",
                  bus4.out_valid, bus4.out_sum, bus4.out_sat);
      end
      cyc();
      n_vec++;
      if (bus4.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL basic_one_cycle got v=%b want 0", bus4.out_valid);
      end
      idle(2);
   endtask

   task automatic test_saturate();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_count = 2'd3;
         cyc();
      end
      n_vec++;
      if (bus3.out_sum !== 3'd7 || bus3.out_sat !== 1'b1) begin
         n_err++;
         $display("FAIL sat_clip got %0d/%b want 7/1", bus3.out_sum, bus3.out_sat);
      end
      n_vec++;
      if (bus4.out_sum !== 4'd12 || bus4.out_sat !== 1'b0) begin
         n_err++;
         $display("FAIL sat_wide got %0d/%b want 12/0", bus4.out_sum, bus4.out_sat);
      end
      for (int i = 0; i < 4; i++) begin
         in_count = (i == 0) ? 2'd1 : 2'd0;
         cyc();
      end
      n_vec++;
      if (bus3.out_sum !== 3'd1 || bus3.out_sat !== 1'b0) begin
         n_err++;
         $display("FAIL sat_flag_reset got %0d/%b want 1/0", bus3.out_sum, bus3.out_sat);
      end
      idle(2);
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_count = (i < 4) ? 2'd1 : 2'd2;
         cyc();
      end
      in_count = 2'd2;
      n_vec++;
      if (bus4.in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL bp_stall got in_ready=%b want 0", bus4.in_ready);
      end
      cyc(); cyc();
      n_vec++;
      if (bus4.out_valid !== 1'b1 || bus4.out_sum !== 4'd4 || bus4.in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL bp_hold got v=%b s=%0d rdy=%b want 1/4/0",
                  bus4.out_valid, bus4.out_sum, bus4.in_ready);
      end
      out_ready = 1'b1;
      #1;
      n_vec++;
      if (bus4.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release got in_ready=%b want 1", bus4.in_ready);
      end
      cyc();
      in_valid = 1'b0;
      n_vec++;
      if (bus4.out_valid !== 1'b1 || bus4.out_sum !== 4'd8 || bus3.out_sum !== 3'd7 ||
          bus3.out_sat !== 1'b1) begin
         n_err++;
         $display("FAIL bp_refill got v=%b s4=%0d s3=%0d sat3=%b want 1/8/7/1",
                  bus4.out_valid, bus4.out_sum, bus3.out_sum, bus3.out_sat);
      end
      cyc();
      n_vec++;
      if (bus4.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL bp_drain got v=%b want 0", bus4.out_valid);
      end
      idle(2);
   endtask

   task automatic test_clear();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_count  = 2'd3;
      cyc(); cyc();
      in_valid = 1'b0;
      clear    = 1'b1;
      cyc();
      clear    = 1'b0;
      in_valid = 1'b1;
      in_count = 2'd1;
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (bus4.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL clr_no_result i=%0d got v=%b want 0", i, bus4.out_valid);
         end
         cyc();
      end
      n_vec++;
      if (bus4.out_sum !== 4'd4 || bus4.out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL clr_sum got v=%b s=%0d want 1/4", bus4.out_valid, bus4.out_sum);
      end
      in_count = 2'd3;
      clear    = 1'b1;
      cyc();
      clear    = 1'b0;
      in_count = 2'd1;
      repeat (4) cyc();
      in_valid = 1'b0;
      n_vec++;
      if (bus4.out_sum !== 4'd4 || bus4.out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL clr_with_sample got v=%b s=%0d want 1/4", bus4.out_valid, bus4.out_sum);
      end
      idle(2);
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_count  = 2'd2;
      repeat (3) cyc();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      n_vec++;
      if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL rst_mid got v=%b rdy=%b want 0/1", bus4.out_valid, bus4.in_ready);
      end
      cyc();
      rst_n     = 1'b1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_count  = 2'd1;
      repeat (4) cyc();
      in_valid = 1'b0;
      n_vec++;
      if (bus4.out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL rst_fill got v=%b want 1", bus4.out_valid);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus4.out_valid !== 1'b0 || bus4.out_sum !== 4'd0 || bus4.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL rst_full got v=%b s=%0d rdy=%b want 0/0/1",
                  bus4.out_valid, bus4.out_sum, bus4.in_ready);
      end
      cyc();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_count  = 2'd2;
      repeat (4) cyc();
      in_valid = 1'b0;
      n_vec++;
      if (bus4.out_valid !== 1'b1 || bus4.out_sum !== 4'd8 || bus3.out_sum !== 3'd7 ||
          bus3.out_sat !== 1'b1) begin
         n_err++;
         $display("FAIL rst_after got v=%b s4=%0d s3=%0d sat3=%b want 1/8/7/1",
                  bus4.out_valid, bus4.out_sum, bus3.out_sum, bus3.out_sat);
      end
      idle(2);
   endtask

   task automatic test_random();
      int start;
      int cycles;
      start  = n_acc;
      cycles = 0;
      while ((n_acc - start) < 20000 && cycles < 60000) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_count  = 2'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 9) < 6);
         clear     = ($urandom_range(0, 199) == 0);
         cyc();
         cycles++;
      end
      n_vec++;
      if ((n_acc - start) < 20000) begin
         n_err++;
         $display("FAIL rand_budget got %0d samples want 20000", n_acc - start);
      end
      idle(4);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL rand_drain got %0d pending want 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturate();
      test_backpressure();
      test_clear();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
